// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and the data path.
// Optional feature: define ARB_STARVE_GUARD_EN to bound consecutive DM wins while IF waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [BE_W-1:0]   dm_be_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_cfg_check
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;

  logic               if_gnt, dm_gnt, if_rvalid, dm_rvalid;
  logic [DATA_W-1:0]  if_rdata, dm_rdata;
  logic               mem_req, mem_we;
  logic [BE_W-1:0]    mem_be;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               busy, done, arb, pick_if, pick_dm;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  logic [STREAK_W-1:0] streak_q, streak_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) streak_q <= '0;
    else         streak_q <= streak_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != IDLE);
    done      = busy && (cnt_q == CNT_W'(1));
    arb       = !busy || done;
`ifdef ARB_STARVE_GUARD_EN
    streak_d  = streak_q;
    pick_if   = arb && if_req_i && (!dm_req_i || (int'(streak_q) >= STARVE_MAX));
`else
    pick_if   = arb && if_req_i && !dm_req_i;
`endif
    pick_dm   = arb && dm_req_i && !pick_if;

    if (done) begin
      if (state_q == BUSY_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata_i;
      end else begin
        dm_rvalid = 1'b1;
        dm_rdata  = we_q ? '0 : mem_rdata_i;
      end
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // The completion cycle doubles as an arbitration cycle for back-to-back issue.
    if (arb) begin
      if (pick_dm) begin
        dm_gnt    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = dm_we_i;
        mem_be    = dm_we_i ? dm_be_i : '1;
        mem_addr  = dm_addr_i;
        mem_wdata = dm_wdata_i;
        state_d   = BUSY_DM;
        cnt_d     = CNT_W'(MEM_LAT);
        we_d      = dm_we_i;
      end else if (pick_if) begin
        if_gnt    = 1'b1;
        mem_req   = 1'b1;
        mem_be    = '1;
        mem_addr  = if_addr_i;
        state_d   = BUSY_IF;
        cnt_d     = CNT_W'(MEM_LAT);
        we_d      = 1'b0;
      end else begin
        state_d   = IDLE;
        cnt_d     = '0;
        we_d      = 1'b0;
      end
`ifdef ARB_STARVE_GUARD_EN
      if (pick_if || !if_req_i)
        streak_d = '0;
      else if (pick_dm && (int'(streak_q) < STARVE_MAX))
        streak_d = streak_q + STREAK_W'(1);
`endif
    end
  end

  // Outputs are forced low combinationally so nothing leaks out while reset is held.
  assign if_gnt_o    = rst_ni & if_gnt;
  assign dm_gnt_o    = rst_ni & dm_gnt;
  assign if_rvalid_o = rst_ni & if_rvalid;
  assign dm_rvalid_o = rst_ni & dm_rvalid;
  assign if_rdata_o  = rst_ni ? if_rdata : '0;
  assign dm_rdata_o  = rst_ni ? dm_rdata : '0;
  assign mem_req_o   = rst_ni & mem_req;
  assign mem_we_o    = rst_ni & mem_we;
  assign mem_be_o    = rst_ni ? mem_be : '0;
  assign mem_addr_o  = rst_ni ? mem_addr : '0;
  assign mem_wdata_o = rst_ni ? mem_wdata : '0;
  assign busy_o      = rst_ni & busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2; honours ARB_STARVE_GUARD_EN if defined.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o, if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i, dm_we_i;
  logic [BE_W-1:0]   dm_be_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o, dm_rvalid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Each cycle: inputs change just after the falling edge, outputs are sampled 1 time unit later.
  task automatic nxt();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h10;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF; dm_addr_i = 32'h20;
    dm_wdata_i = 32'h55; mem_rdata_i = 32'hA5A5A5A5;

    // Reset held with both requests active: everything low.
    nxt(); nxt(); #1;
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_dm_gnt", dm_gnt_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_busy", busy_o, 0);

    nxt(); rst_ni = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    #1; chk("idle_busy", busy_o, 0);

    // Lone fetch.
    nxt(); if_req_i = 1'b1; if_addr_i = 32'h100; #1;
    chk("if_gnt", if_gnt_o, 1);
    chk("if_mem_req", mem_req_o, 1);
    chk("if_mem_addr", mem_addr_o, 32'h100);
    chk("if_mem_be", mem_be_o, 4'hF);
    chk("if_mem_we", mem_we_o, 0);
    nxt(); if_req_i = 1'b0; #1;
    chk("if_t1_busy", busy_o, 1);
    chk("if_t1_rvalid", if_rvalid_o, 0);
    chk("if_t1_mem_req", mem_req_o, 0);
    chk("if_t1_mem_addr", mem_addr_o, 0);
    nxt(); mem_rdata_i = 32'hDEADBEEF; #1;
    chk("if_t2_rvalid", if_rvalid_o, 1);
    chk("if_t2_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("if_t2_busy", busy_o, 1);
    nxt(); #1;
    chk("if_t3_busy", busy_o, 0);
    chk("if_t3_rvalid", if_rvalid_o, 0);
    chk("if_t3_rdata", if_rdata_o, 0);

    // Simultaneous IF and DM load: DM wins, IF issues back-to-back at DM completion.
    nxt(); if_req_i = 1'b1; if_addr_i = 32'h200; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80; #1;
    chk("both_dm_gnt", dm_gnt_o, 1);
    chk("both_if_gnt", if_gnt_o, 0);
    chk("both_mem_addr", mem_addr_o, 32'h80);
    nxt(); dm_req_i = 1'b0; #1;
    chk("both_t1_if_gnt", if_gnt_o, 0);
    nxt(); mem_rdata_i = 32'hCAFE0001; #1;
    chk("both_t2_dm_rvalid", dm_rvalid_o, 1);
    chk("both_t2_dm_rdata", dm_rdata_o, 32'hCAFE0001);
    chk("both_t2_if_gnt", if_gnt_o, 1);
    chk("both_t2_mem_addr", mem_addr_o, 32'h200);
    chk("both_t2_if_rvalid", if_rvalid_o, 0);
    nxt(); if_req_i = 1'b0; #1;
    chk("both_t3_dm_rvalid", dm_rvalid_o, 0);
    nxt(); mem_rdata_i = 32'h00000011; #1;
    chk("both_t4_if_rvalid", if_rvalid_o, 1);
    chk("both_t4_if_rdata", if_rdata_o, 32'h11);
    chk("both_t4_dm_rvalid", dm_rvalid_o, 0);
    nxt(); #1; chk("both_t5_busy", busy_o, 0);

    // DM store.
    nxt(); dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF; dm_addr_i = 32'h40; dm_wdata_i = 32'h12345678; #1;
    chk("st_gnt", dm_gnt_o, 1);
    chk("st_mem_we", mem_we_o, 1);
    chk("st_mem_be", mem_be_o, 4'hF);
    chk("st_mem_wdata", mem_wdata_o, 32'h12345678);
    chk("st_mem_addr", mem_addr_o, 32'h40);
    nxt(); dm_req_i = 1'b0; dm_we_i = 1'b0; #1;
    chk("st_t1_mem_we", mem_we_o, 0);
    nxt(); mem_rdata_i = 32'hFFFFFFFF; #1;
    chk("st_t2_rvalid", dm_rvalid_o, 1);
    chk("st_t2_rdata", dm_rdata_o, 0);
    chk("st_t2_if_rvalid", if_rvalid_o, 0);
    nxt(); #1; chk("st_t3_busy", busy_o, 0);

    // Reset in the middle of a DM load abandons it.
    nxt(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80; #1;
    chk("rl_gnt", dm_gnt_o, 1);
    nxt(); dm_req_i = 1'b0; if_req_i = 1'b1; rst_ni = 1'b0; #1;
    chk("rl_busy", busy_o, 0);
    chk("rl_if_gnt", if_gnt_o, 0);
    chk("rl_mem_req", mem_req_o, 0);
    chk("rl_mem_addr", mem_addr_o, 0);
    chk("rl_dm_rvalid", dm_rvalid_o, 0);
    nxt(); rst_ni = 1'b1; if_req_i = 1'b0; #1;
    chk("rl_rel_busy", busy_o, 0);
    chk("rl_rel_dm_rvalid", dm_rvalid_o, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("rl_post_dm_rvalid", dm_rvalid_o, 0);
      chk("rl_post_busy", busy_o, 0);
    end

    // IF request withdrawn while DM is busy.
    nxt(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h84; #1;
    chk("wd_dm_gnt", dm_gnt_o, 1);
    nxt(); dm_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h300; #1;
    chk("wd_t1_if_gnt", if_gnt_o, 0);
    nxt(); if_req_i = 1'b0; mem_rdata_i = 32'h77; #1;
    chk("wd_t2_dm_rvalid", dm_rvalid_o, 1);
    chk("wd_t2_if_gnt", if_gnt_o, 0);
    chk("wd_t2_busy", busy_o, 1);
    nxt(); #1;
    chk("wd_t3_busy", busy_o, 0);
    chk("wd_t3_if_gnt", if_gnt_o, 0);
    nxt(); #1;
    chk("wd_t4_if_rvalid", if_rvalid_o, 0);

    // Continuous DM traffic with IF pending, 20 arbitration cycles.
    nxt(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500; if_req_i = 1'b1; if_addr_i = 32'h600;
    for (int i = 0; i < 20; i++) begin
      logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = ((i % 5) == 4);
`else
      exp_if = 1'b0;
`endif
      #1;
      chk("sv_if_gnt", if_gnt_o, exp_if);
      chk("sv_dm_gnt", dm_gnt_o, !exp_if);
      nxt(); nxt();
    end
    dm_req_i = 1'b0; if_req_i = 1'b0;
    nxt(); #1; chk("sv_end_busy", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
